// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg : shared MIPS pipeline types for the EX/MEM stage
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } xm_state_t;

   localparam int XM_TIMEOUT_CYCLES = 255;

   // Everything the EX/MEM latch carries forward, bubble = all zeros
   typedef struct packed {
      word_t    alu_out;
      word_t    store;
      word_t    pc4;
      regbits_t wsel;
      logic     mem_to_reg;
      logic     reg_write;
      logic     dren;
      logic     dwen;
      logic     halt;
   } xm_fields_t;

   function automatic logic is_mem_op(input xm_fields_t f);
      return f.dren | f.dwen;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_execute_memory_if.sv
// ============================================================================
// pipeline_execute_memory_if : data-cache request/response bundle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface pipeline_execute_memory_if;
   import cpu_types_pkg::*;

   logic  dhit;
   word_t dmemload;
   logic  dmemREN;
   logic  dmemWEN;
   word_t dmemaddr;
   word_t dmemstore;

   modport master (
      input  dhit, dmemload,
      output dmemREN, dmemWEN, dmemaddr, dmemstore
   );

   modport slave (
      output dhit, dmemload,
      input  dmemREN, dmemWEN, dmemaddr, dmemstore
   );

endinterface

`default_nettype wire

// File: rtl/pipeline_execute_memory_watchdog.sv
// ============================================================================
// mem_watchdog : counts consecutive stalled request cycles, sticky error flag
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_watchdog
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = XM_TIMEOUT_CYCLES
) (
   input  logic CLK,
   input  logic RST,
   input  logic stall_i,
   output logic mem_err_o
);

   localparam int                c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES);

   logic [c_cnt_w-1:0] cnt_q, cnt_d;
   logic               err_q, err_d;

   // A stall run is contiguous, so any non-stalled cycle restarts the count
   always_comb begin
      cnt_d = '0;
      if (stall_i) begin
         cnt_d = (cnt_q == c_limit) ? cnt_q : cnt_q + 1'b1;
      end
      err_d = err_q | (cnt_d == c_limit);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign mem_err_o = err_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_execute_memory.sv
// ============================================================================
// pipeline_execute_memory : EX/MEM latch with data-cache handshake and stall
// Optional request watchdog built when XM_TIMEOUT_EN is defined.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pipeline_execute_memory
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = XM_TIMEOUT_CYCLES
) (
   input  logic     CLK,
   input  logic     RST,
   input  logic     en_xm,
   input  logic     flush_xm,
   input  word_t    alu_out_ex,
   input  word_t    store_ex,
   input  regbits_t wsel_ex,
   input  logic     MemToReg_ex,
   input  logic     RegWrite_ex,
   input  logic     dREN_ex,
   input  logic     dWEN_ex,
   input  logic     halt_ex,
   input  word_t    pc4_ex,
   pipeline_execute_memory_if.master dcif,
   output word_t    alu_out_mem,
   output word_t    pc4_mem,
   output word_t    dload_mem,
   output regbits_t wsel_mem,
   output logic     MemToReg_mem,
   output logic     RegWrite_mem,
   output logic     halt_mem,
   output logic     stall_xm,
   output logic     mem_err
);

   xm_state_t  state_q;
   xm_fields_t mem_q, ex_d;
   word_t      hold_q;
   logic       stall;
   logic       adv;

   assign stall = (state_q == REQ) & ~dcif.dhit;
   assign adv   = en_xm & ~stall & ~mem_q.halt;

   always_comb begin
      ex_d = '0;
      if (!flush_xm) begin
         ex_d.alu_out    = alu_out_ex;
         ex_d.store      = store_ex;
         ex_d.pc4        = pc4_ex;
         ex_d.wsel       = wsel_ex;
         ex_d.mem_to_reg = MemToReg_ex;
         ex_d.reg_write  = RegWrite_ex;
         ex_d.dren       = dREN_ex;
         ex_d.dwen       = dWEN_ex;
         ex_d.halt       = halt_ex;
      end
   end

   // A hit that lands while the hazard unit holds us must be parked until advance
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         mem_q   <= '0;
         hold_q  <= '0;
      end else if (adv) begin
         mem_q   <= ex_d;
         state_q <= is_mem_op(ex_d) ? REQ : IDLE;
      end else if ((state_q == REQ) && dcif.dhit && !en_xm) begin
         hold_q  <= dcif.dmemload;
         state_q <= DONE;
      end
   end

   assign dcif.dmemREN   = (state_q == REQ) & mem_q.dren;
   assign dcif.dmemWEN   = (state_q == REQ) & mem_q.dwen;
   assign dcif.dmemaddr  = mem_q.alu_out;
   assign dcif.dmemstore = mem_q.store;

   always_comb begin
      dload_mem = '0;
      case (state_q)
         REQ:     dload_mem = dcif.dmemload;
         DONE:    dload_mem = hold_q;
         default: dload_mem = '0;
      endcase
   end

   assign alu_out_mem  = mem_q.alu_out;
   assign pc4_mem      = mem_q.pc4;
   assign wsel_mem     = mem_q.wsel;
   assign MemToReg_mem = mem_q.mem_to_reg;
   assign RegWrite_mem = mem_q.reg_write;
   assign halt_mem     = mem_q.halt;
   assign stall_xm     = stall;

`ifdef XM_TIMEOUT_EN
   mem_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .CLK       (CLK),
      .RST       (RST),
      .stall_i   (stall),
      .mem_err_o (mem_err)
   );
`else
   assign mem_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/pipeline_execute_memory.md
# pipeline_execute_memory

EX/MEM pipeline register for the five-stage MIPS pipeline. It sits directly downstream of the decode/execute latch and the ALU. It captures execute-stage results and carries them into the memory stage. It also owns the data-cache request handshake: it drives the request while a load or store is outstanding, stalls the front of the pipe until the request completes, and holds load data when a hit arrives while the pipe is frozen.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles without `dhit` before `mem_err` sets. Used only with XM_TIMEOUT_EN.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- en_xm  in  1  external enable from the hazard unit.
- flush_xm  in  1  on advance, load a bubble instead of EX inputs.
- alu_out_ex  in  32  ALU result / memory address.
- store_ex  in  32  store data (forwarded rt).
- wsel_ex  in  5  destination register after the RegDst mux.
- MemToReg_ex, RegWrite_ex, dREN_ex, dWEN_ex, halt_ex  in  1 each  control bits.
- pc4_ex  in  32  PC+4 (JAL writeback).
- dhit  in  1  data-cache hit/complete.
- dmemload  in  32  data-cache read data.
- dmemREN, dmemWEN  out  1 each  cache request.
- dmemaddr, dmemstore  out  32 each  cache address and store data.
- alu_out_mem, pc4_mem, dload_mem  out  32 each  MEM-stage values.
- wsel_mem  out  5.
- MemToReg_mem, RegWrite_mem, halt_mem  out  1 each.
- stall_xm  out  1  freezes IF/ID, ID/EX and this stage; MEM/WB loads only when this is low.
- mem_err  out  1  request timeout flag.

## Operation
- Reset: all registered fields are 0, the state is IDLE, and every output is 0.
- The request is outstanding only while the state is REQ:
  - dmemREN = (state==REQ) & dREN_mem
  - dmemWEN = (state==REQ) & dWEN_mem
  - dmemaddr = alu_out_mem
  - dmemstore = store_mem
- stall_xm = (state==REQ) & !dhit.
- Advance: adv = en_xm & !stall_xm & !halt_mem.
  - On adv, all fields load from the `_ex` inputs.
  - If flush_xm is also high, all fields load 0 instead (bubble).
- Load data:
  - In REQ, dload_mem = dmemload.
  - In DONE, dload_mem = the held value.
  - In IDLE, dload_mem = 0.
- States:
  - IDLE: on adv, go to REQ if the loaded instruction has dREN|dWEN and is not flushed; otherwise stay in IDLE.
  - REQ:
    - dhit & adv: re-evaluate the new instruction as from IDLE.
    - dhit & !en_xm: capture dmemload into the hold register, go to DONE.
    - !dhit: stay in REQ.
  - DONE: requests stay deasserted (no re-issue). On adv, re-evaluate as from IDLE.
- Halt:
  - Once halt_mem=1, the stage ignores adv and never issues a request. It holds until RST.
  - A halt instruction cannot carry dREN or dWEN.
- dREN_ex and dWEN_ex both high is illegal. The bench asserts against it.

## Timing
- Latency: 1 cycle, EX inputs to `_mem` outputs.
- The request asserts the cycle after the load and stays asserted until the dhit cycle inclusive.
- A store or load completes in the dhit cycle. The next instruction is accepted on that same edge (zero bubble on hit).
- A cache with a 0-cycle hit produces no stall.
- RST mid-request drops dmemREN/dmemWEN combinationally and returns the state to IDLE.

## Configuration
- XM_TIMEOUT_EN defined:
  - A counter increments each cycle in REQ with !dhit and clears on leaving REQ.
  - When it reaches TIMEOUT_CYCLES, mem_err sets. It is sticky until RST.
  - The stall is unaffected.
- XM_TIMEOUT_EN undefined: no counter is built and mem_err is tied to 0.

## Structure
- xm_state_t (IDLE, REQ, DONE) and the default TIMEOUT_CYCLES belong in cpu_types_pkg.
- Use word_t for the 32-bit fields and regbits_t for wsel.
- One sub-module, mem_watchdog: the counter and sticky flag, instantiated only under XM_TIMEOUT_EN.

## Test plan
- Load: alu_out_ex=0x100 with dREN, dhit after 3 cycles, dmemload=0xDEADBEEF.
  - stall_xm is high for 3 cycles, dmemREN is high for 4 cycles, and dload_mem=0xDEADBEEF in the dhit cycle.
- Store: wsel irrelevant, store_ex=0x1234, dhit in the first request cycle.
  - dmemWEN pulses 1 cycle with dmemaddr/dmemstore correct, stall_xm stays 0, and the next instruction is loaded on the same edge.
- Hit during freeze: dREN, dhit while en_xm=0, then en_xm=1 two cycles later.
  - State goes to DONE and dmemREN drops after dhit.
  - dload_mem holds the captured word until advance.
- Flush on advance: flush_xm=1 with RegWrite_ex=1 and dREN_ex=1.
  - All `_mem` fields are 0, no request is issued, and the state is IDLE.
- Halt: halt_ex=1 loaded, then new EX inputs are presented.
  - halt_mem stays 1 and the fields are frozen. RST clears everything asynchronously.
- With XM_TIMEOUT_EN and TIMEOUT_CYCLES=4: dREN with no dhit.
  - mem_err=1 after 4 stalled cycles and stays 1 after dhit arrives.
